mux_rr_n: RTL and testbench

Parametrised, registered N-input multiplexer with valid/ready handshake and two selection modes: fixed select, the classic mux behaviour, and round-robin arbitration. It sits in the MIPS CPU datapath wherever several producers share one consumer, for example instruction fetch and data access sharing a memory port, or several writeback sources feeding one register-file port. One output register stage gives a 1-cycle latency and full throughput of one transfer per cycle.

---
 rtl/mux_rr_n.sv | 94 +++++++++
 tb/tb_mux_rr_n.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n.sv
// Registered N-input multiplexer with valid/ready handshake.
// It supports fixed-select mode and round-robin arbitration, with one output stage.
module mux_rr_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      select,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic             w_cand;
  logic             w_xfer;
  logic [SELW-1:0]  w_grant;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_data;

  assign w_load = !r_out_valid || out_ready;
  assign w_xfer = w_cand && w_load && !reset;

  always_comb begin : grant_sel
    int idx;
    idx     = 0;
    w_cand  = 1'b0;
    w_grant = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (int'(select) == i && in_valid[i]) begin
          w_cand  = 1'b1;
          w_grant = SELW'(i);
        end
      end
    end else begin
      // Scan farthest-first so the channel closest to r_ptr is the last hit and wins.
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(r_ptr) + k) % N;
        if (in_valid[idx]) begin
          w_cand  = 1'b1;
          w_grant = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    w_data   = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) begin
        w_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_xfer;
      end
    end
  end

  assign w_ptr_nxt = (w_grant == SELW'(N - 1)) ? '0 : w_grant + 1'b1;

  // Output stage: the register holds until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_sel   <= w_grant;
      if (mode) r_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: directed scenarios plus random traffic against a
// behavioural grant/output model checked on every falling edge.
module tb_mux_rr_n;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int W5 = 8;
  localparam int N5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, mode, out_ready;
  logic [SW-1:0]   select;
  logic [N-1:0]    in_valid, in_ready;
  logic [N*W-1:0]  in_data;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;

  logic             reset5, mode5, or5, ov5;
  logic [2:0]       select5, os5;
  logic [N5-1:0]    valid5, ready5;
  logic [N5*W5-1:0] data5;
  logic [W5-1:0]    od5;

  mux_rr_n #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  mux_rr_n #(.WIDTH(W5), .N(N5)) dut5 (
    .clk(clk), .reset(reset5), .mode(mode5), .select(select5),
    .in_valid(valid5), .in_data(data5), .in_ready(ready5),
    .out_valid(ov5), .out_data(od5), .out_sel(os5),
    .out_ready(or5)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: output holding register plus the last channel granted in round-robin mode.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_sel   = 0;
  int           m_last  = N - 1;

  always @(negedge clk) begin : scoreboard
    logic [N-1:0] er;
    bit           load, found;
    int           g, c;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_sel", out_sel, m_sel);
    er = '0; found = 0; g = 0;
    if (!reset) begin
      load = !m_valid || out_ready;
      if (!mode) begin
        if (int'(select) < N && in_valid[select]) begin found = 1; g = int'(select); end
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && in_valid[c]) begin found = 1; g = c; end
        end
      end
      if (found && load) er[g] = 1'b1;
    end
    chk("in_ready", in_ready, er);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = N - 1;
    end else if (er != '0) begin
      m_valid = 1'b1; m_data = in_data[g*W +: W]; m_sel = g;
      if (mode) m_last = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  initial begin
    reset = 1'b1; mode = 1'b1; select = '0; in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(32'hA0 + i);
    reset5 = 1'b1; mode5 = 1'b0; select5 = '0; valid5 = '0; data5 = '0; or5 = 1'b1;

    // Reset hold with every channel valid
    repeat (3) begin
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sel", out_sel, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    step();
    reset = 1'b0;
    #1 chk("first_grant", in_ready, 4'b0001);

    // Round-robin fairness
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_sel", out_sel, k % 4);
      chk("rr_valid", out_valid, 1);
    end

    // Fixed select
    mode = 1'b0; select = 2'd2;
    #1 chk("fix_ready0", in_ready, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fix_ready", in_ready, 4'b0100);
      chk("fix_data", out_data, 32'hA2);
      chk("fix_sel", out_sel, 2);
    end

    // Sparse valid and wrap-around
    mode = 1'b1; in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sparse_sel", out_sel, (k % 2) ? 3 : 0);
    end
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0110;
    #1 chk("wrap_ready", in_ready, 4'b0010);
    step();
    chk("wrap_sel", out_sel, 1);

    // Backpressure
    mode = 1'b0; select = 2'd1; in_valid = 4'b0010; in_data[1*W +: W] = 32'h55;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      select = SW'($urandom); mode = 1'($urandom); in_valid = '1;
      #1;
      chk("bp_data", out_data, 32'h55);
      chk("bp_sel", out_sel, 1);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1; mode = 1'b0; select = 2'd2; in_valid = 4'b0100;
    in_data[2*W +: W] = 32'h77;
    #1 chk("bp_reload_ready", in_ready, 4'b0100);
    step();
    chk("bp_reload_data", out_data, 32'h77);
    chk("bp_reload_sel", out_sel, 2);

    // Reset while an output is held
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_ready", in_ready, 4'b0001);
    step();
    chk("midrst_sel", out_sel, 0);
    chk("midrst_out", out_data, in_data[W-1:0]);

    // Random traffic
    repeat (3000) begin
      mode      = 1'($urandom);
      select    = SW'($urandom);
      in_valid  = N'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    step();

    // Out-of-range select on a 5-channel instance
    reset5 = 1'b0; mode5 = 1'b0; select5 = 3'd1; valid5 = '1; or5 = 1'b1;
    for (int i = 0; i < N5; i++) data5[i*W5 +: W5] = W5'(8'h10 + i);
    #1 chk("n5_ready1", ready5, 5'b00010);
    step();
    chk("n5_data", od5, 8'h11);
    chk("n5_valid", ov5, 1);
    select5 = 3'd7;
    #1 chk("n5_oor_ready", ready5, 0);
    step();
    chk("n5_drain_valid", ov5, 0);
    chk("n5_hold_data", od5, 8'h11);
    chk("n5_hold_sel", os5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
